// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_sequencer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_sequencer_fa.sv
// Purely combinational 1-bit full-adder cell built from two half-adders.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic x1;
  logic g1;
  logic g2;

  // Two cascaded half-adders; their generate terms never overlap,
  // so XOR combines them exactly like an OR would.
  always_comb begin
    x1   = a ^ b;
    g1   = a & b;
    s    = x1 ^ cin;
    g2   = x1 & cin;
    cout = g1 ^ g2;
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder front end: accepts operands, feeds one bit pair per clock
// (LSB first) to a full-adder cell, and returns sum and carry-out.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic             accept;

  full_adder_1b u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (c_q),
    .s   (fa_s),
    .cout(fa_co)
  );

  // Handshake and end-of-operand qualifiers
  always_comb begin
    accept   = (state_q == IDLE) && in_valid;
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == SHIFT);
    out_valid = (state_q == DONE);
  end

  // Datapath: operand load on accept, one bit per cycle while shifting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      a_sh_q <= op_a;
      b_sh_q <= op_b;
      c_q    <= carry_in;
      cnt_q  <= '0;
    end else if (state_q == SHIFT) begin
      // Sum bits enter at the MSB so bit 0 lands in the LSB after WIDTH shifts
      sum_q  <= {fa_s, sum_q[WIDTH-1:1]};
      a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
      c_q    <= fa_co;
      cnt_q  <= cnt_q + CW'(1);
      if (last_bit) begin
        cout_q <= fa_co;
      end
    end
  end

  // Result outputs hold the last value until the next operation overwrites them
  always_comb begin
    sum       = sum_q;
    carry_out = cout_q;
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and random checks of the bit-serial adder sequencer (WIDTH=8).
module tb_serial_add_sequencer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int unsigned checks;
  int unsigned failures;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One full transaction: accept, count latency, check result, optional stall in DONE.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int unsigned stall);
    logic [W:0]  exp;
    int unsigned k;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    check("idle_in_ready", 32'(in_ready), 32'd1);
    op_a      = a;
    op_b      = b;
    carry_in  = ci;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = ~b;
    k = 0;
    while (!out_valid && k < 100) begin
      step();
      k++;
    end
    check("latency", k, W);
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("carry_out", 32'(carry_out), 32'(exp[W]));
    for (int unsigned i = 0; i < stall; i++) begin
      step();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_sum", 32'(sum), 32'(exp[W-1:0]));
    end
    out_ready = 1'b1;
    step();
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int unsigned pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    carry_in  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic adds and overflow boundaries
    run_add(8'h5A, 8'h3C, 1'b0, 0);
    check("5A+3C", 32'({carry_out, sum}), 32'h096);
    run_add(8'hFF, 8'h01, 1'b0, 0);
    check("FF+01", 32'({carry_out, sum}), 32'h100);
    run_add(8'hFF, 8'hFF, 1'b1, 0);
    check("FF+FF+1", 32'({carry_out, sum}), 32'h1FF);

    // Backpressure for 5 cycles in DONE
    run_add(8'h12, 8'h34, 1'b0, 5);
    check("12+34", 32'(sum), 32'h46);

    // in_valid pulsed during SHIFT must be ignored
    op_a     = 8'h01;
    op_b     = 8'h01;
    carry_in = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    check("shift_busy", 32'(busy), 32'd1);
    op_a     = 8'hAA;
    op_b     = 8'h55;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    pulses = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      if (out_valid) begin
        pulses++;
        check("ign_sum", 32'(sum), 32'h02);
        check("ign_carry_out", 32'(carry_out), 32'd0);
        out_ready = 1'b1;
      end
      step();
    end
    check("ign_pulses", pulses, 32'd1);
    check("ign_idle", 32'(in_ready), 32'd1);

    // Reset in the middle of SHIFT (counter at 4)
    op_a      = 8'h33;
    op_b      = 8'h44;
    carry_in  = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    step();
    rst_n = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_carry_out", 32'(carry_out), 32'd0);
    step();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    run_add(8'h0F, 8'h01, 1'b0, 0);
    check("0F+01", 32'({carry_out, sum}), 32'h010);

    // Random sweep with random DONE stalls
    for (int unsigned n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_add(ra, rb, rc, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
